// File: rtl/cue_pkg.sv
// Shared types and constants for the cue aiming/shooting controller.
package cue_pkg;

  localparam int Q8_FRAC    = 8;
  localparam int ANGLE_BITS = 6;

  typedef enum logic [2:0] {
    HIDDEN,
    AIM,
    CHARGE,
    STRIKE,
    COOLDOWN
  } cue_state_t;

endpackage

// File: rtl/cue_trig_lut.sv
// Combinational 64-step direction table: angle index -> signed Q8 cos/sin.
module cue_trig_lut
  import cue_pkg::*;
(
  input  logic [ANGLE_BITS-1:0] angle,
  output logic signed [31:0]    cosQ,
  output logic signed [31:0]    sinQ
);

  // First quadrant of round(256*cos(k*2pi/64)), k = 0..16.
  function automatic logic signed [31:0] quarter(input logic [4:0] i);
    case (i)
      5'd0:    return 256;
      5'd1:    return 255;
      5'd2:    return 251;
      5'd3:    return 245;
      5'd4:    return 237;
      5'd5:    return 226;
      5'd6:    return 213;
      5'd7:    return 198;
      5'd8:    return 181;
      5'd9:    return 162;
      5'd10:   return 142;
      5'd11:   return 121;
      5'd12:   return 98;
      5'd13:   return 74;
      5'd14:   return 50;
      5'd15:   return 25;
      default: return 0;
    endcase
  endfunction

  function automatic logic signed [31:0] cos_of(input logic [ANGLE_BITS-1:0] a);
    logic [4:0] i;
    i = {1'b0, a[3:0]};
    case (a[5:4])
      2'd0:    return quarter(i);
      2'd1:    return -quarter(5'd16 - i);
      2'd2:    return -quarter(i);
      default: return quarter(5'd16 - i);
    endcase
  endfunction

  // sin(k) is cos(k - quarter turn), so one table serves both outputs.
  always_comb begin
    cosQ = cos_of(angle);
    sinQ = cos_of(angle - 6'd16);
  end

endmodule

// File: rtl/cue_controller.sv
// Cue aiming/charging/stroke state machine feeding cue_object and ball physics.
module cue_controller
  import cue_pkg::*;
#(
  parameter int OBJECT_RADIUS   = 16,
  parameter int GAP_MIN         = 4,
  parameter int POWER_STEP      = 2,
  parameter int MAX_POWER       = 15,
  parameter int CHARGE_FRAMES   = 4,
  parameter int ROT_FRAMES      = 2,
  parameter int STRIKE_STEP     = 8,
  parameter int SPEED_SCALE     = 1,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic               clk,
  input  logic               resetN,
  input  logic               startOfFrame,
  input  logic               ball_stopped,
  input  logic signed [31:0] ballX,
  input  logic signed [31:0] ballY,
  input  logic               key_left,
  input  logic               key_right,
  input  logic               key_charge,
  output logic signed [31:0] closeEdgeX,
  output logic signed [31:0] closeEdgeY,
  output logic signed [31:0] farEdgeX,
  output logic signed [31:0] farEdgeY,
  output logic               cue_enable,
  output logic               hit_pulse,
  output logic signed [31:0] hit_speedX,
  output logic signed [31:0] hit_speedY
);

  localparam int LENGTH   = OBJECT_RADIUS * 8;
  localparam int GAP_REST = OBJECT_RADIUS + GAP_MIN;

  cue_state_t state, state_nxt;
  logic [ANGLE_BITS-1:0] angle, angle_nxt;
  logic signed [31:0] power, power_nxt, gap, gap_nxt;
  logic signed [31:0] rot_cnt, rot_cnt_nxt, chg_cnt, chg_cnt_nxt, cd_cnt, cd_cnt_nxt;
  logic signed [31:0] speed_x_nxt, speed_y_nxt;
  logic signed [31:0] cosQ, sinQ;
  logic signed [31:0] close_x_p0, close_y_p0, far_x_p0, far_y_p0;
  logic key_charge_q, charge_rise, charge_fall, hit_nxt;

  function automatic logic signed [31:0] q8_scale(input logic signed [31:0] coef,
                                                  input logic signed [31:0] mag);
    return (coef * mag) >>> Q8_FRAC;
  endfunction

  function automatic logic signed [31:0] power_inc_sat(input logic signed [31:0] p);
    return (p >= MAX_POWER) ? MAX_POWER : p + 1;
  endfunction

  cue_trig_lut u_trig (
    .angle (angle),
    .cosQ  (cosQ),
    .sinQ  (sinQ)
  );

  assign charge_rise = key_charge & ~key_charge_q;
  assign charge_fall = ~key_charge & key_charge_q;
  assign cue_enable  = (state == AIM) || (state == CHARGE) || (state == STRIKE);

  // p0: edge geometry from current angle/gap and live ball position
  always_comb begin
    close_x_p0 = ballX - q8_scale(cosQ, gap);
    close_y_p0 = ballY - q8_scale(sinQ, gap);
    far_x_p0   = ballX - q8_scale(cosQ, gap + LENGTH);
    far_y_p0   = ballY - q8_scale(sinQ, gap + LENGTH);
  end

  always_ff @(posedge clk) begin
    if (!resetN) state <= HIDDEN;
    else         state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    angle_nxt   = angle;
    power_nxt   = power;
    gap_nxt     = gap;
    rot_cnt_nxt = rot_cnt;
    chg_cnt_nxt = chg_cnt;
    cd_cnt_nxt  = cd_cnt;
    hit_nxt     = 1'b0;
    speed_x_nxt = hit_speedX;
    speed_y_nxt = hit_speedY;
    case (state)
      HIDDEN: if (startOfFrame && ball_stopped) begin
        state_nxt   = AIM;
        power_nxt   = 0;
        gap_nxt     = GAP_REST;
        rot_cnt_nxt = 0;
      end
      AIM: begin
        if (!ball_stopped) begin
          state_nxt   = HIDDEN;
          rot_cnt_nxt = 0;
        end else if (charge_rise) begin
          state_nxt   = CHARGE;
          power_nxt   = 0;
          chg_cnt_nxt = 0;
          rot_cnt_nxt = 0;
        end else if (key_left == key_right) begin
          rot_cnt_nxt = 0;
        end else if (startOfFrame) begin
          if (rot_cnt == ROT_FRAMES - 1) begin
            rot_cnt_nxt = 0;
            angle_nxt   = key_right ? angle + 6'd1 : angle - 6'd1;
          end else begin
            rot_cnt_nxt = rot_cnt + 1;
          end
        end
      end
      CHARGE: begin
        if (charge_fall) begin
          state_nxt   = (power == 0) ? AIM : STRIKE;
          chg_cnt_nxt = 0;
        end else if (startOfFrame) begin
          if (chg_cnt == CHARGE_FRAMES - 1) begin
            chg_cnt_nxt = 0;
            power_nxt   = power_inc_sat(power);
            gap_nxt     = GAP_REST + power_inc_sat(power) * POWER_STEP;
          end else begin
            chg_cnt_nxt = chg_cnt + 1;
          end
        end
      end
      STRIKE: if (startOfFrame) begin
        if (gap - STRIKE_STEP <= OBJECT_RADIUS) begin
          gap_nxt     = OBJECT_RADIUS;
          hit_nxt     = 1'b1;
          speed_x_nxt = q8_scale(cosQ, power * SPEED_SCALE);
          speed_y_nxt = q8_scale(sinQ, power * SPEED_SCALE);
          state_nxt   = COOLDOWN;
          cd_cnt_nxt  = 0;
        end else begin
          gap_nxt = gap - STRIKE_STEP;
        end
      end
      COOLDOWN: if (startOfFrame) begin
        if (cd_cnt == COOLDOWN_FRAMES - 1) begin
          cd_cnt_nxt = 0;
          state_nxt  = HIDDEN;
        end else begin
          cd_cnt_nxt = cd_cnt + 1;
        end
      end
      default: state_nxt = HIDDEN;
    endcase
  end

  // p1: registered control state and edge outputs
  always_ff @(posedge clk) begin
    if (!resetN) begin
      angle        <= '0;
      power        <= '0;
      gap          <= GAP_REST;
      rot_cnt      <= '0;
      chg_cnt      <= '0;
      cd_cnt       <= '0;
      key_charge_q <= 1'b0;
      hit_pulse    <= 1'b0;
      hit_speedX   <= '0;
      hit_speedY   <= '0;
      closeEdgeX   <= '0;
      closeEdgeY   <= '0;
      farEdgeX     <= '0;
      farEdgeY     <= '0;
    end else begin
      angle        <= angle_nxt;
      power        <= power_nxt;
      gap          <= gap_nxt;
      rot_cnt      <= rot_cnt_nxt;
      chg_cnt      <= chg_cnt_nxt;
      cd_cnt       <= cd_cnt_nxt;
      key_charge_q <= key_charge;
      hit_pulse    <= hit_nxt;
      hit_speedX   <= speed_x_nxt;
      hit_speedY   <= speed_y_nxt;
      closeEdgeX   <= close_x_p0;
      closeEdgeY   <= close_y_p0;
      farEdgeX     <= far_x_p0;
      farEdgeY     <= far_y_p0;
    end
  end

endmodule

// File: doc/cue_controller.md
Name: cue_controller

Overview:
- Upstream stage of the cue renderer (cue_object).
- Owns the aiming/shooting state machine for the white ball: rotates the aim angle, charges strike power (pull-back), animates the forward stroke, and issues a one-cycle hit command to the ball physics.
- Produces closeEdgeX/Y, farEdgeX/Y and cue_enable in exactly the form cue_object consumes.

Parameters:
- OBJECT_RADIUS, 16: ball radius in pixels; cue length LENGTH = OBJECT_RADIUS*8.
- GAP_MIN, 4: pixels between ball surface and cue tip at zero power.
- POWER_STEP, 2: extra pull-back pixels per power unit.
- MAX_POWER, 15: power saturation value.
- CHARGE_FRAMES, 4: frames per power increment.
- ROT_FRAMES, 2: frames per angle step while a rotate key is held.
- STRIKE_STEP, 8: pixels the tip advances per frame during the stroke.
- SPEED_SCALE, 1: power-to-speed multiplier.
- COOLDOWN_FRAMES, 2: frames the cue stays hidden after a hit.

Ports:
- clk, in, 1: clock.
- resetN, in, 1: synchronous active-low reset.
- startOfFrame, in, 1: one-cycle frame tick.
- ball_stopped, in, 1: all balls stationary (level).
- ballX, in, int: white ball centre X.
- ballY, in, int: white ball centre Y.
- key_left, in, 1: rotate counter-clockwise (level, debounced).
- key_right, in, 1: rotate clockwise (level, debounced).
- key_charge, in, 1: hold to charge, release to shoot.
- closeEdgeX, out, int: cue tip X.
- closeEdgeY, out, int: cue tip Y.
- farEdgeX, out, int: cue butt X.
- farEdgeY, out, int: cue butt Y.
- cue_enable, out, 1: cue visible.
- hit_pulse, out, 1: one-cycle strike command.
- hit_speedX, out, int: initial ball velocity X, valid with hit_pulse.
- hit_speedY, out, int: initial ball velocity Y, valid with hit_pulse.

Behaviour:

Clock and reset:
- Single clock; reset is synchronous, active-low (resetN sampled on posedge clk).
- Reset from any state: state=HIDDEN, angle=0, power=0, gap=OBJECT_RADIUS+GAP_MIN, all counters 0.
- Output reset values: edges=0, cue_enable=0, hit_pulse=0, hit_speedX/Y=0.
- Reset mid-stroke produces no hit_pulse.

Direction and trig LUT:
- Angle index is 6 bits (0..63), wrapping in both directions.
- Direction (cosQ, sinQ) comes from a 64-entry LUT, signed Q8: round(256*cos(k*2π/64)), round(256*sin(k*2π/64)).
- k=0 gives (256,0); k=16 gives (0,256). +Y is screen-down.
- The direction is the strike direction.

Geometry:
- All arithmetic is signed 32-bit; right shifts are arithmetic.
- closeEdgeX = ballX - ((cosQ*gap)>>>8); closeEdgeY = ballY - ((sinQ*gap)>>>8).
- farEdgeX = ballX - ((cosQ*(gap+LENGTH))>>>8); farEdgeY likewise with sinQ.
- Edges are computed combinationally from the registered angle/gap/ball inputs, then registered: one cycle of latency.
- Edges update every cycle, including while the cue is hidden.

Frame-tick events:
- All timing events (rotation, charge, stroke, cooldown) advance only on startOfFrame.
- key_charge edge detection uses a registered previous value, updated every cycle.

State machine (cue_enable=1 in AIM, CHARGE, STRIKE):
- HIDDEN: on startOfFrame with ball_stopped=1 -> AIM, with power=0 and gap=OBJECT_RADIUS+GAP_MIN.
- AIM, rotation: exactly one of key_left/key_right held -> angle ∓1 every ROT_FRAMES frames. Both held or neither held -> no rotation; rotation counter clears.
- AIM, charge: key_charge rising edge -> CHARGE, power=0, charge counter=0.
- AIM, balls moving: ball_stopped=0 -> HIDDEN.
- CHARGE: rotation keys are ignored. Each frame the charge counter increments; at CHARGE_FRAMES-1 it clears and power increments, saturating at MAX_POWER. gap = OBJECT_RADIUS+GAP_MIN+power*POWER_STEP.
- CHARGE, falling edge of key_charge: power=0 -> AIM (no shot); power>0 -> STRIKE.
- STRIKE, each frame: if gap-STRIKE_STEP <= OBJECT_RADIUS, then gap=OBJECT_RADIUS, hit_pulse=1 for one cycle, hit_speedX=(cosQ*power*SPEED_SCALE)>>>8, hit_speedY likewise with sinQ, -> COOLDOWN. Otherwise gap -= STRIKE_STEP.
- COOLDOWN: cue_enable=0; after COOLDOWN_FRAMES frames -> HIDDEN.
- hit_speedX/Y hold their last value after the pulse.

Decomposition:
- Package cue_pkg:
  - state enum (HIDDEN, AIM, CHARGE, STRIKE, COOLDOWN);
  - Q8 fraction constant (8);
  - ANGLE_BITS=6.
- Sub-module cue_trig_lut:
  - combinational angle -> signed cosQ/sinQ;
  - the controller instantiates one.

Test Plan:
- Reset, ballX=320, ballY=240, ball_stopped=1, one frame tick -> AIM, cue_enable=1, closeEdge=(300,240), farEdge=(172,240).
- In AIM, key_right held for 32 frames -> angle=16; closeEdge=(320,220), farEdge=(320,92). key_left+key_right held together -> angle unchanged.
- key_charge held for 8 frames at angle 0 -> power=2, gap=24, closeEdgeX=296. Released -> STRIKE.
- Charge to saturation (≥60 frames), release at angle 0 -> gap sequence 50,42,34,26,18; 5th stroke frame gives gap=16, one hit_pulse cycle, hit_speedX=15, hit_speedY=0, then cue_enable=0.
- Press and release key_charge within one frame -> power=0, back to AIM, no hit_pulse. Separately: ball_stopped=0 during AIM -> HIDDEN; stays hidden until ball_stopped=1 on a tick.
- Assert resetN=0 mid-STRIKE -> next cycle all outputs at reset values, no hit_pulse; angle=0.
